// File: rtl/multi_strip_driver_if.sv
// Memory read port shared by all strip channels: one strobe out, one data pulse back.
interface multi_strip_driver_if #(
  parameter int CH_W   = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 24
);
  logic              mem_read;
  logic [CH_W-1:0]   mem_channel;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_valid;

  modport master (
    output mem_read, mem_channel, mem_address,
    input  mem_data, mem_valid
  );

  modport slave (
    input  mem_read, mem_channel, mem_address,
    output mem_data, mem_valid
  );
endinterface

// File: rtl/multi_strip_driver.sv
// Parallel xx6812-style strip driver. Pixel words for the next LED are fetched into a
// shadow buffer while the current LED shifts out of per-channel shift registers.
//
// state    | meaning
// IDLE     | waiting for frame_start
// PREFETCH | reading LED 0 of every channel into the shadow buffer
// SEND     | serialising one LED per channel, refilling shadow with the next LED
// LATCH    | strips held low for the latch gap
module multi_strip_driver #(
  parameter int CHANNELS     = 4,
  parameter int LEDS         = 150,
  parameter int BITS_PER_LED = 24,
  parameter int BIT_CYCLES   = 15,
  parameter int T0H_CYCLES   = 4,
  parameter int T1H_CYCLES   = 8,
  parameter int LATCH_CYCLES = 960,
  parameter int ADDR_W       = (LEDS > 1) ? $clog2(LEDS) : 1,
  parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clock_12mhz,
  input  logic                  reset_n,
  input  logic                  frame_start,
  input  logic [CHANNELS-1:0]   channel_enable,
  multi_strip_driver_if.master  mem,
  output logic [CHANNELS-1:0]   strip,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);
  localparam int BC_W = $clog2(BIT_CYCLES);
  localparam int BI_W = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
  localparam int LT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [BC_W-1:0]   BIT_LAST   = BC_W'(BIT_CYCLES - 1);
  localparam logic [BC_W-1:0]   T0H        = BC_W'(T0H_CYCLES);
  localparam logic [BC_W-1:0]   T1H        = BC_W'(T1H_CYCLES);
  localparam logic [BI_W-1:0]   BIDX_LAST  = BI_W'(BITS_PER_LED - 1);
  localparam logic [ADDR_W-1:0] LED_LAST   = ADDR_W'(LEDS - 1);
  localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(CHANNELS - 1);
  localparam logic [LT_W-1:0]   LATCH_LOAD = LT_W'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PREFETCH, SEND, LATCH} state_t;

  state_t                                  state;
  logic [CHANNELS-1:0]                     en_q;
  logic [CHANNELS-1:0][BITS_PER_LED-1:0]   shadow;
  logic [CHANNELS-1:0][BITS_PER_LED-1:0]   shadow_nx;
  logic [CHANNELS-1:0][BITS_PER_LED-1:0]   shift;
  logic                                    shadow_full;
  logic                                    outstanding;
  logic [CH_W-1:0]                         fetch_ch;
  logic [ADDR_W-1:0]                       fetch_led;
  logic [ADDR_W-1:0]                       led_idx;
  logic [BI_W-1:0]                         bit_idx;
  logic [BC_W-1:0]                         bit_cnt;
  logic [BC_W-1:0]                         cnt_nx;
  logic [LT_W-1:0]                         latch_cnt;
  logic                                    mem_read_q;
  logic [CH_W-1:0]                         mem_channel_q;
  logic [ADDR_W-1:0]                       mem_address_q;
  logic                                    accept;
  logic                                    last_word;
  logic                                    full_nx;
  logic [CHANNELS-1:0]                     high_nx;

  assign mem.mem_read    = mem_read_q;
  assign mem.mem_channel = mem_channel_q;
  assign mem.mem_address = mem_address_q;

  // Merge an arriving word into the shadow view and work out the next strip levels.
  // The merged view lets a word landing on the LED boundary still count as in time.
  always_comb begin
    accept    = mem.mem_valid && outstanding;
    last_word = accept && (fetch_ch == CH_LAST);
    full_nx   = shadow_full || last_word;
    shadow_nx = shadow;
    if (accept) shadow_nx[fetch_ch] = mem.mem_data;
    cnt_nx  = bit_cnt + 1'b1;
    high_nx = '0;
    for (int c = 0; c < CHANNELS; c++)
      high_nx[c] = en_q[c] && (cnt_nx < (shift[c][BITS_PER_LED-1] ? T1H : T0H));
  end

  // Frame sequencer, fetch handshake and bit timing; later assignments override the fetch defaults.
  always_ff @(posedge clock_12mhz) begin
    if (!reset_n) begin
      state         <= IDLE;
      strip         <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      underrun      <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_channel_q <= '0;
      mem_address_q <= '0;
      en_q          <= '0;
      shadow        <= '0;
      shift         <= '0;
      shadow_full   <= 1'b0;
      outstanding   <= 1'b0;
      fetch_ch      <= '0;
      fetch_led     <= '0;
      led_idx       <= '0;
      bit_idx       <= '0;
      bit_cnt       <= '0;
      latch_cnt     <= '0;
    end else begin
      mem_read_q <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;

      if (accept) begin
        shadow <= shadow_nx;
        if (last_word) begin
          outstanding <= 1'b0;
          shadow_full <= 1'b1;
        end else begin
          fetch_ch      <= fetch_ch + 1'b1;
          mem_read_q    <= 1'b1;
          mem_channel_q <= fetch_ch + 1'b1;
          mem_address_q <= fetch_led;
        end
      end

      case (state)
        IDLE: begin
          if (frame_start) begin
            en_q          <= channel_enable;
            busy          <= 1'b1;
            state         <= PREFETCH;
            shadow_full   <= 1'b0;
            fetch_ch      <= '0;
            fetch_led     <= '0;
            outstanding   <= 1'b1;
            mem_read_q    <= 1'b1;
            mem_channel_q <= '0;
            mem_address_q <= '0;
          end
        end

        PREFETCH: begin
          if (last_word) begin
            shift       <= shadow_nx;
            shadow_full <= 1'b0;
            state       <= SEND;
            strip       <= en_q;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            led_idx     <= '0;
            if (LEDS > 1) begin
              fetch_led     <= fetch_led + 1'b1;
              fetch_ch      <= '0;
              outstanding   <= 1'b1;
              mem_read_q    <= 1'b1;
              mem_channel_q <= '0;
              mem_address_q <= fetch_led + 1'b1;
            end
          end
        end

        SEND: begin
          if (bit_cnt != BIT_LAST) begin
            bit_cnt <= cnt_nx;
            strip   <= high_nx;
          end else if (bit_idx != BIDX_LAST) begin
            bit_cnt <= '0;
            bit_idx <= bit_idx + 1'b1;
            strip   <= en_q;
            for (int c = 0; c < CHANNELS; c++)
              shift[c] <= {shift[c][BITS_PER_LED-2:0], 1'b0};
          end else if (led_idx == LED_LAST) begin
            state     <= LATCH;
            strip     <= '0;
            latch_cnt <= LATCH_LOAD;
          end else if (full_nx) begin
            shift       <= shadow_nx;
            shadow_full <= 1'b0;
            led_idx     <= led_idx + 1'b1;
            bit_idx     <= '0;
            bit_cnt     <= '0;
            strip       <= en_q;
            if (fetch_led != LED_LAST) begin
              fetch_led     <= fetch_led + 1'b1;
              fetch_ch      <= '0;
              outstanding   <= 1'b1;
              mem_read_q    <= 1'b1;
              mem_channel_q <= '0;
              mem_address_q <= fetch_led + 1'b1;
            end
          end else begin
            // Data for the next LED is late: abort the frame and drop the pending read.
            underrun    <= 1'b1;
            strip       <= '0;
            state       <= LATCH;
            latch_cnt   <= LATCH_LOAD;
            outstanding <= 1'b0;
            shadow_full <= 1'b0;
            mem_read_q  <= 1'b0;
          end
        end

        LATCH: begin
          if (latch_cnt == '0) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            latch_cnt <= latch_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
